// File: rtl/mac_result_drain.sv
// Purpose: snapshot the mac_array accumulator bank, requantize it to OUT_WIDTH and stream it out one row per beat.
// Latency: snapshot taken at edge k; the first row is valid after edge k+1; at most one row every 2 cycles.
// Backpressure: out_row, out_row_idx and out_last hold while out_valid & !out_ready; acc_ready is low for the whole drain.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   acc_valid/acc_ready   accumulator bank handshake; a snapshot is taken when both are high
//   accumulators          MAC_WIDTH x MAC_WIDTH signed accumulators, element [r][i] at (r*MAC_WIDTH+i)*ACC_WIDTH
//   requant_en/scale/shift requant controls, captured together with the accumulators
//   out_valid/out_ready   row stream handshake
//   out_row               MAC_WIDTH signed OUT_WIDTH elements, element i at i*OUT_WIDTH
//   out_row_idx/out_last  row number of out_row and final-row flag
//   sat_count             number of elements clipped so far in the current tile (sticky at 0xFFFF)
//   busy                  a tile is being drained
module mac_result_drain #(
    parameter int MAC_WIDTH   = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    acc_valid,
    output logic                                    acc_ready,
    input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] accumulators,
    input  logic                                    requant_en,
    input  logic [SCALE_WIDTH-1:0]                  scale,
    input  logic [SHIFT_WIDTH-1:0]                  shift,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [MAC_WIDTH*OUT_WIDTH-1:0]          out_row,
    output logic [$clog2(MAC_WIDTH)-1:0]            out_row_idx,
    output logic                                    out_last,
    output logic [15:0]                             sat_count,
    output logic                                    busy
);

    localparam int IW       = $clog2(MAC_WIDTH);
    localparam int ROW_BITS = MAC_WIDTH * ACC_WIDTH;
    localparam int BANK_BITS = MAC_WIDTH * ROW_BITS;
    // Full-precision product width, plus one bit of headroom for the rounding add.
    localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
    localparam int RW = PW + 1;

    // Saturation bounds, sign-extended to the working width.
    localparam logic signed [RW-1:0] OMAX = signed'({{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Snapshot of everything the drain needs, so upstream is free once it is taken.
    logic [BANK_BITS-1:0]   snap_acc;
    logic                   snap_en;
    logic [SCALE_WIDTH-1:0] snap_scale;
    logic [SHIFT_WIDTH-1:0] snap_shift;

    logic [IW-1:0]                  row;
    logic [ROW_BITS-1:0]            row_acc;
    logic [MAC_WIDTH*OUT_WIDTH-1:0] row_res;
    logic [MAC_WIDTH-1:0]           clip;
    logic [16:0]                    sat_sum;
    logic [15:0]                    sat_next;

    logic take;
    logic emit_done;
    logic row_is_last;

    assign take        = acc_valid & acc_ready;
    assign emit_done   = (state_q == EMIT) & out_ready;
    assign row_is_last = (row == IW'(MAC_WIDTH - 1));

    // Requantize one accumulator. Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] requant(
        input logic signed [ACC_WIDTH-1:0]   a,
        input logic                          en,
        input logic        [SCALE_WIDTH-1:0] sc,
        input logic        [SHIFT_WIDTH-1:0] sh
    );
        logic signed [PW-1:0] a_x;
        logic signed [PW-1:0] s_x;
        logic signed [PW-1:0] p;
        logic signed [RW-1:0] r;
        logic        [OUT_WIDTH:0] res;
        a_x = PW'(a);
        // Scale is unsigned: a zero MSB keeps it positive in the signed multiply.
        s_x = PW'($signed({1'b0, sc}));
        if (en) begin
            p = a_x * s_x;
        end else begin
            p = a_x;
        end
        r = RW'(p);
        // Round half up: add half an LSB of the result before the arithmetic shift.
        if (en && (sh != '0)) begin
            r = r + (RW'(1) << (sh - SHIFT_WIDTH'(1)));
            r = r >>> sh;
        end
        if (r > OMAX) begin
            res = {1'b1, OMAX[OUT_WIDTH-1:0]};
        end else if (r < OMIN) begin
            res = {1'b1, OMIN[OUT_WIDTH-1:0]};
        end else begin
            res = {1'b0, r[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = out_last ? IDLE : CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        acc_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == EMIT);
    end

    // ---------------- Snapshot ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_acc   <= '0;
            snap_en    <= 1'b0;
            snap_scale <= '0;
            snap_shift <= '0;
        end else if (take) begin
            snap_acc   <= accumulators;
            snap_en    <= requant_en;
            snap_scale <= scale;
            snap_shift <= shift;
        end
    end

    // ---------------- Row counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (take) begin
            row <= '0;
        end else if (emit_done && !out_last) begin
            row <= row + 1'b1;
        end
    end

    // ---------------- Current row select ----------------
    always_comb begin
        row_acc = '0;
        for (int r = 0; r < MAC_WIDTH; r++) begin
            if (row == IW'(r)) begin
                row_acc = snap_acc[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    // ---------------- Per-element requantization ----------------
    for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_elem
        logic [OUT_WIDTH:0] rq;
        always_comb begin
            rq = requant(row_acc[i*ACC_WIDTH +: ACC_WIDTH], snap_en, snap_scale, snap_shift);
        end
        assign row_res[i*OUT_WIDTH +: OUT_WIDTH] = rq[OUT_WIDTH-1:0];
        assign clip[i]                           = rq[OUT_WIDTH];
    end

    // Clip counter, pinned at all-ones once it would wrap.
    always_comb begin
        sat_sum = {1'b0, sat_count};
        for (int i = 0; i < MAC_WIDTH; i++) begin
            sat_sum = sat_sum + {16'd0, clip[i]};
        end
        sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // ---------------- Output row registers ----------------
    // Loaded only in CALC, so they are naturally stable for the whole EMIT stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row     <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
            sat_count   <= '0;
        end else begin
            if (take) begin
                sat_count <= '0;
            end else if (state_q == CALC) begin
                sat_count <= sat_next;
            end
            if (state_q == CALC) begin
                out_row     <= row_res;
                out_row_idx <= row;
                out_last    <= row_is_last;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

    localparam int MW = 8;
    localparam int AW = 32;
    localparam int NV = 17;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               acc_valid = 1'b0;
    logic               acc_ready;
    logic [MW*MW*AW-1:0] accumulators = '0;
    logic               requant_en = 1'b0;
    logic [15:0]        scale = '0;
    logic [4:0]         shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [63:0]        out_row;
    logic [2:0]         out_row_idx;
    logic               out_last;
    logic [15:0]        sat_count;
    logic               busy;

    mac_result_drain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .accumulators (accumulators),
        .requant_en   (requant_en),
        .scale        (scale),
        .shift        (shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_row_idx  (out_row_idx),
        .out_last     (out_last),
        .sat_count    (sat_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] acc;
        logic        en;
        logic [15:0] sc;
        logic [4:0]  sh;
        logic [7:0]  exp;
        logic        clip;
    } vec_t;

    vec_t        vt[NV];
    int          nvec = 0;
    int          nerr = 0;
    logic [63:0] got_row[8];
    logic [2:0]  got_idx[8];
    logic        got_last[8];
    int          got_n;
    int          n;
    int          stalls;
    logic [63:0] hold_row;
    logic [2:0]  hold_idx;
    logic [63:0] e;
    logic [MW*MW*AW-1:0] a;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [MW*MW*AW-1:0] fill(input logic [31:0] v);
        logic [MW*MW*AW-1:0] f;
        for (int k = 0; k < MW*MW; k++) f[k*AW +: AW] = v;
        return f;
    endfunction

    function automatic logic [MW*MW*AW-1:0] ramp();
        logic [MW*MW*AW-1:0] f;
        for (int k = 0; k < MW*MW; k++) f[k*AW +: AW] = 32'(k);
        return f;
    endfunction

    function automatic logic [63:0] ramp_row(input int r);
        logic [63:0] f;
        for (int i = 0; i < MW; i++) f[i*8 +: 8] = 8'(r*8 + i);
        return f;
    endfunction

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic accept_tile(input logic [MW*MW*AW-1:0] av, input logic en,
                               input logic [15:0] sc, input logic [4:0] sh);
        int w;
        w = 0;
        while (!acc_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", acc_ready, 1);
        accumulators = av;
        requant_en   = en;
        scale        = sc;
        shift        = sh;
        acc_valid    = 1'b1;
        @(negedge clk);
        acc_valid    = 1'b0;
    endtask

    // Records every beat with out_ready held high; returns in IDLE at a negedge.
    task automatic drain();
        out_ready = 1'b1;
        got_n = 0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) begin
                got_row[got_n]  = out_row;
                got_idx[got_n]  = out_row_idx;
                got_last[got_n] = out_last;
                got_n++;
                if (out_last || got_n == 8) break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{32'd1000,       1'b1, 16'd1,      5'd3,  8'd125,  1'b0};
        vt[1]  = '{32'd1004,       1'b1, 16'd1,      5'd3,  8'd126,  1'b0};
        vt[2]  = '{-32'sd1004,     1'b1, 16'd1,      5'd3,  8'h83,   1'b0};
        vt[3]  = '{32'd7,          1'b1, 16'd1,      5'd3,  8'd1,    1'b0};
        vt[4]  = '{32'd5,          1'b1, 16'd1,      5'd0,  8'd5,    1'b0};
        vt[5]  = '{32'd16129,      1'b0, 16'd0,      5'd0,  8'd127,  1'b1};
        vt[6]  = '{-32'sd200,      1'b0, 16'd0,      5'd0,  8'h80,   1'b1};
        vt[7]  = '{32'h7FFFFFFF,   1'b1, 16'hFFFF,   5'd0,  8'd127,  1'b1};
        vt[8]  = '{-32'sd1,        1'b1, 16'd1,      5'd1,  8'h00,   1'b0};
        vt[9]  = '{-32'sd3,        1'b1, 16'd1,      5'd1,  8'hFF,   1'b0};
        vt[10] = '{32'd100,        1'b1, 16'd3,      5'd2,  8'd75,   1'b0};
        vt[11] = '{32'd127,        1'b0, 16'd2,      5'd7,  8'd127,  1'b0};
        vt[12] = '{32'd128,        1'b0, 16'd0,      5'd0,  8'd127,  1'b1};
        vt[13] = '{-32'sd129,      1'b0, 16'd0,      5'd0,  8'h80,   1'b1};
        vt[14] = '{32'h80000000,   1'b1, 16'hFFFF,   5'd31, 8'h80,   1'b1};
        vt[15] = '{-32'sd128,      1'b0, 16'd0,      5'd0,  8'h80,   1'b0};
        vt[16] = '{32'd43,         1'b1, 16'd3,      5'd0,  8'd127,  1'b1};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_row_idx", out_row_idx, 0);
        chk("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- bypass ramp with latency check ----
        accept_tile(ramp(), 1'b0, 16'd0, 5'd0);
        chk("lat_no_valid_yet", out_valid, 0);
        chk("lat_busy", busy, 1);
        chk("lat_not_ready", acc_ready, 0);
        @(negedge clk);
        chk("lat_first_valid", out_valid, 1);
        drain();
        chk("byp_beats", got_n, 8);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("byp_row%0d", r), got_row[r], ramp_row(r));
            chk($sformatf("byp_idx%0d", r), got_idx[r], r);
            chk($sformatf("byp_last%0d", r), got_last[r], (r == 7));
        end
        chk("byp_sat", sat_count, 0);
        chk("byp_idle", busy, 0);

        // ---- arithmetic vector table: every element of the tile carries the vector ----
        for (int k = 0; k < NV; k++) begin
            accept_tile(fill(vt[k].acc), vt[k].en, vt[k].sc, vt[k].sh);
            drain();
            chk($sformatf("v%0d_beats", k), got_n, 8);
            for (int r = 0; r < 8; r++)
                chk($sformatf("v%0d_row%0d", k, r), got_row[r], {8{vt[k].exp}});
            chk($sformatf("v%0d_sat", k), sat_count, vt[k].clip ? 64 : 0);
        end

        // ---- saturation count: two clips, then one on the next tile ----
        a = '0;
        a[0 +: 32]         = 32'd16129;
        a[(3*8+5)*32 +: 32] = -32'sd200;
        accept_tile(a, 1'b0, 16'd0, 5'd0);
        drain();
        chk("sat2_row0", got_row[0], 64'd127);
        e = '0;
        e[5*8 +: 8] = 8'h80;
        chk("sat2_row3", got_row[3], e);
        chk("sat2_row5", got_row[5], 0);
        chk("sat2_count", sat_count, 2);
        a = '0;
        a[63*32 +: 32] = 32'h7FFFFFFF;
        accept_tile(a, 1'b1, 16'hFFFF, 5'd0);
        drain();
        e = '0;
        e[7*8 +: 8] = 8'd127;
        chk("sat1_row7", got_row[7], e);
        chk("sat1_row0", got_row[0], 0);
        chk("sat1_count", sat_count, 1);

        // ---- backpressure, isolation, acc_valid while busy, back-to-back tile ----
        accept_tile(ramp(), 1'b1, 16'd1, 5'd0);
        accumulators = fill(32'd2);
        requant_en   = 1'b1;
        scale        = 16'd3;
        shift        = 5'd1;
        acc_valid    = 1'b1;
        chk("busy_not_ready", acc_ready, 0);
        stalls = 0;
        n = 0;
        for (int cyc = 0; cyc < 300 && n < 8; cyc++) begin
            @(negedge clk);
            if (stalls > 0 && stalls <= 5) begin
                chk("bp_valid_held", out_valid, 1);
                chk("bp_row_stable", out_row, hold_row);
                chk("bp_idx_stable", out_row_idx, hold_idx);
            end
            if (out_valid) begin
                if (out_row_idx == 3'd2 && stalls < 5) begin
                    if (stalls == 0) begin
                        hold_row = out_row;
                        hold_idx = out_row_idx;
                    end
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    if (out_row_idx == 3'd2) stalls = 6;
                    out_ready   = 1'b1;
                    got_row[n]  = out_row;
                    got_idx[n]  = out_row_idx;
                    got_last[n] = out_last;
                    chk("bp_no_accept", acc_ready, 0);
                    n++;
                end
            end
        end
        chk("bp_beats", n, 8);
        chk("bp_stalls", stalls, 6);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("iso_row%0d", r), got_row[r], ramp_row(r));
            chk($sformatf("bp_idx%0d", r), got_idx[r], r);
        end
        @(negedge clk);
        chk("ready_after_last", acc_ready, 1);
        @(negedge clk);
        chk("second_captured", busy, 1);
        acc_valid = 1'b0;
        @(negedge clk);
        chk("second_valid", out_valid, 1);
        drain();
        chk("second_beats", got_n, 8);
        for (int r = 0; r < 8; r++)
            chk($sformatf("second_row%0d", r), got_row[r], {8{8'd3}});

        // ---- reset mid-drain ----
        accept_tile(ramp(), 1'b0, 16'd0, 5'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_row_idx == 3'd4) break;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("mid_at_row4", out_row_idx, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", acc_ready, 1);
        chk("mid_rst_idx", out_row_idx, 0);
        chk("mid_rst_row", out_row, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        accept_tile(fill(32'd9), 1'b0, 16'd0, 5'd0);
        drain();
        chk("post_rst_beats", got_n, 8);
        chk("post_rst_idx0", got_idx[0], 0);
        chk("post_rst_row0", got_row[0], {8{8'd9}});
        chk("post_rst_last", got_last[7], 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
